frame_max_tracker: RTL and testbench

- Streaming peak detector that sits directly downstream of the mode-selectable greater-than comparator.
- Accepts a valid/ready sample stream divided into frames by a last flag.
- Tracks the running maximum of each frame, signed or unsigned per frame, and the position at which it occurred.
- Emits one result per frame on a valid/ready output port and holds it until the result is accepted.

---
 rtl/frame_max_tracker_pkg.sv | 17 +
 rtl/mag_cmp_gt.sv | 29 ++
 rtl/frame_max_tracker.sv | 120 ++++++++++++
 tb/tb_frame_max_tracker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_max_tracker_pkg.sv
// Shared definitions for the frame peak tracker.
// Contents: default widths, FSM state encoding, comparison mode constants.
package frame_max_tracker_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first sample of a frame
        ACCUM = 2'd1,   // inside a frame, tracking the running maximum
        HOLD  = 2'd2    // result presented, input stalled until accepted
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mag_cmp_gt.sv
// Mode-selectable strict greater-than comparator.
// Ports:
//   a, b  : operands (WIDTH bits)
//   mode  : MODE_SIGNED (two's complement) or MODE_UNSIGNED
//   agtb  : 1 when a > b under the selected interpretation
module mag_cmp_gt
    import frame_max_tracker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             agtb
);

    // With equal MSBs both interpretations order the low bits the same way.
    // With differing MSBs the operand holding the set MSB is larger when
    // unsigned and smaller (negative) when signed.
    always_comb begin
        if (a[WIDTH-1] == b[WIDTH-1])
            agtb = (a[WIDTH-2:0] > b[WIDTH-2:0]);
        else if (mode == MODE_SIGNED)
            agtb = b[WIDTH-1];
        else
            agtb = a[WIDTH-1];
    end

endmodule

// File: rtl/frame_max_tracker.sv
// Streaming per-frame peak detector.
// Accepts a valid/ready sample stream split into frames by s_last, tracks
// the frame maximum (signed or unsigned, chosen by mode on the first sample)
// and its first position, and presents one held result per frame.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   mode                 : 1 = signed, 0 = unsigned; sampled on first sample
//   s_valid/s_ready      : input handshake; s_data sample, s_last end of frame
//   m_valid/m_ready      : result handshake
//   m_max, m_index       : frame maximum and its 0-based position
//   m_count, m_ovf       : sample count mod 2^IDX_W, count reached 2^IDX_W
module frame_max_tracker
    import frame_max_tracker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_max,
    output logic [IDX_W-1:0] m_index,
    output logic [IDX_W-1:0] m_count,
    output logic             m_ovf
);

    state_t           state;
    logic             mode_r;
    logic [WIDTH-1:0] cur_max;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] cnt;
    logic             ovf;

    logic             agtb;
    logic             xfer;
    logic [WIDTH-1:0] nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] nxt_cnt;
    logic             nxt_ovf;

    assign s_ready = (state != HOLD);
    assign xfer    = s_valid && s_ready;

    mag_cmp_gt #(.WIDTH(WIDTH)) u_cmp (
        .a    (s_data),
        .b    (cur_max),
        .mode (mode_r),
        .agtb (agtb)
    );

    // Frame statistics after absorbing the current sample. The output
    // registers load from these so the final sample takes part in the
    // comparison without an extra cycle.
    always_comb begin
        if (state == IDLE) begin
            nxt_max = s_data;
            nxt_idx = '0;
            nxt_cnt = IDX_W'(1);
            nxt_ovf = 1'b0;
        end else begin
            nxt_max = agtb ? s_data : cur_max;
            nxt_idx = agtb ? cnt    : cur_idx;
            nxt_cnt = cnt + IDX_W'(1);
            nxt_ovf = ovf | (nxt_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode_r  <= MODE_UNSIGNED;
            cur_max <= '0;
            cur_idx <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            m_valid <= 1'b0;
            m_max   <= '0;
            m_index <= '0;
            m_count <= '0;
            m_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (xfer) begin
                        if (state == IDLE)
                            mode_r <= mode;
                        cur_max <= nxt_max;
                        cur_idx <= nxt_idx;
                        cnt     <= nxt_cnt;
                        ovf     <= nxt_ovf;
                        if (s_last) begin
                            m_max   <= nxt_max;
                            m_index <= nxt_idx;
                            m_count <= nxt_cnt;
                            m_ovf   <= nxt_ovf;
                            m_valid <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_max_tracker.sv
module tb_frame_max_tracker;
    import frame_max_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       reset, mode, s_valid, s_last, m_ready;
    logic [7:0] s_data;
    logic       s_ready, m_valid, m_ovf;
    logic [7:0] m_max, m_index, m_count;
    logic       s_ready2, m_valid2, m_ovf2;
    logic [7:0] m_max2;
    logic [1:0] m_index2, m_count2;

    always #5 clk = ~clk;

    frame_max_tracker #(.WIDTH(8), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_max(m_max), .m_index(m_index), .m_count(m_count), .m_ovf(m_ovf)
    );

    // Same stream into a narrow-count instance to reach the wrap boundary.
    frame_max_tracker #(.WIDTH(8), .IDX_W(2)) dut2 (
        .clk(clk), .reset(reset), .mode(mode), .s_valid(s_valid), .s_ready(s_ready2),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
        .m_max(m_max2), .m_index(m_index2), .m_count(m_count2), .m_ovf(m_ovf2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last, input logic md);
        int t;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last; mode = md;
        t = 0;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: s_ready stuck at 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic gap();
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
    endtask

    // Called right after the last push: result must be up one cycle later.
    task automatic wait_result();
        @(negedge clk);
        s_valid = 1'b0;
        chk("latency_m_valid", m_valid, 1);
        chk("latency_m_valid2", m_valid2, 1);
    endtask

    task automatic accept(input int hold, input logic [7:0] emax);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
            chk("hold_s_ready", s_ready, 0);
            chk("hold_m_valid", m_valid, 1);
            chk("hold_m_max", m_max, emax);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("accept_m_valid", m_valid, 0);
        chk("accept_s_ready", s_ready, 1);
        chk("accept_s_ready2", s_ready2, 1);
    endtask

    function automatic int sval(input logic [7:0] x, input logic md);
        return md ? int'($signed(x)) : int'(x);
    endfunction

    // Reference: first position of the largest value, counts by arithmetic.
    function automatic void model(input logic [7:0] q[$], input logic md, input int iw,
                                  output logic [7:0] mx, output int idx, output int cnt,
                                  output logic ov);
        int b = 0;
        for (int i = 1; i < q.size(); i++)
            if (sval(q[i], md) > sval(q[b], md)) b = i;
        mx  = q[b];
        idx = b % (1 << iw);
        cnt = q.size() % (1 << iw);
        ov  = (q.size() >= (1 << iw));
    endfunction

    typedef struct packed {
        logic            md;
        logic [3:0]      n;
        logic [7:0][7:0] d;
        logic [7:0]      emax;
        logic [7:0]      eidx;
        logic [7:0]      ecnt;
        logic            eovf;
        logic [3:0]      hold;
    } vec_t;

    function automatic vec_t mk(input logic md, input int n, input logic [31:0] w,
                                input logic [7:0] emax, input logic [7:0] eidx,
                                input logic [7:0] ecnt, input int hold);
        vec_t v;
        v.md = md; v.n = 4'(n); v.d = {32'h0, w};
        v.emax = emax; v.eidx = eidx; v.ecnt = ecnt; v.eovf = 1'b0; v.hold = 4'(hold);
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[5];
        logic [7:0] q[$];
        logic [7:0] mx;
        int         idx, cnt, n;
        logic       ov, md0, md;
        logic [7:0] d;
        logic [7:0] specials[4];

        reset = 1'b1; mode = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_max", m_max, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_count", m_count, 0);
        chk("rst_m_ovf", m_ovf, 0);
        reset = 1'b0;

        // samples packed lowest byte first
        tbl[0] = mk(MODE_UNSIGNED, 4, 32'h057F8010, 8'h80, 1, 4, 5);
        tbl[1] = mk(MODE_SIGNED,   4, 32'h057F8010, 8'h7F, 2, 4, 0);
        tbl[2] = mk(MODE_SIGNED,   2, 32'h000080FF, 8'hFF, 0, 2, 0);
        tbl[3] = mk(MODE_UNSIGNED, 3, 32'h00333333, 8'h33, 0, 3, 0);
        tbl[4] = mk(MODE_UNSIGNED, 1, 32'h000000A5, 8'hA5, 0, 1, 0);
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < int'(tbl[v].n); i++)
                push(tbl[v].d[i], (i == int'(tbl[v].n) - 1), tbl[v].md);
            wait_result();
            chk($sformatf("tbl%0d_m_max", v), m_max, tbl[v].emax);
            chk($sformatf("tbl%0d_m_index", v), m_index, tbl[v].eidx);
            chk($sformatf("tbl%0d_m_count", v), m_count, tbl[v].ecnt);
            chk($sformatf("tbl%0d_m_ovf", v), m_ovf, tbl[v].eovf);
            accept(int'(tbl[v].hold), tbl[v].emax);
        end

        // count wrap on the 2-bit instance
        push(8'd1, 0, 0); push(8'd2, 0, 0); push(8'd3, 0, 0); push(8'd4, 0, 0); push(8'd9, 1, 0);
        wait_result();
        chk("ovf2_m_max", m_max2, 9);
        chk("ovf2_m_index", m_index2, 0);
        chk("ovf2_m_count", m_count2, 1);
        chk("ovf2_m_ovf", m_ovf2, 1);
        chk("ovf_wide_m_index", m_index, 4);
        chk("ovf_wide_m_count", m_count, 5);
        chk("ovf_wide_m_ovf", m_ovf, 0);
        accept(0, 8'd9);
        push(8'd7, 0, 0); push(8'd3, 1, 0);
        wait_result();
        chk("ovf2_next_m_ovf", m_ovf2, 0);
        chk("ovf2_next_m_max", m_max2, 7);
        chk("ovf2_next_m_count", m_count2, 2);
        accept(0, 8'd7);

        // reset in the middle of a frame
        push(8'h50, 0, 0); push(8'h60, 0, 0);
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_max", m_max, 0);
        chk("midrst_m_index", m_index, 0);
        chk("midrst_m_count", m_count, 0);
        chk("midrst_m_ovf", m_ovf, 0);
        chk("midrst_m_valid2", m_valid2, 0);
        // reset while a result is pending
        push(8'h44, 1, 0);
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("holdrst_m_valid", m_valid, 0);
        chk("holdrst_m_max", m_max, 0);
        chk("holdrst_s_ready", s_ready, 1);
        push(8'h01, 0, 1); push(8'h02, 1, 1);
        wait_result();
        chk("postrst_m_max", m_max, 8'h02);
        chk("postrst_m_index", m_index, 1);
        chk("postrst_m_count", m_count, 2);
        accept(0, 8'h02);

        // randomized frames, mid-frame mode toggles, gaps, back-pressure
        specials[0] = 8'h00; specials[1] = 8'h7F; specials[2] = 8'h80; specials[3] = 8'hFF;
        for (int f = 0; f < 60; f++) begin
            n   = $urandom_range(1, 9);
            md0 = 1'($urandom);
            q.delete();
            for (int i = 0; i < n; i++) begin
                d  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
                md = (i == 0) ? md0 : 1'($urandom);
                if ($urandom_range(0, 3) == 0) gap();
                push(d, (i == n - 1), md);
                q.push_back(d);
            end
            wait_result();
            model(q, md0, 8, mx, idx, cnt, ov);
            chk($sformatf("rnd%0d_m_max", f), m_max, mx);
            chk($sformatf("rnd%0d_m_index", f), m_index, idx);
            chk($sformatf("rnd%0d_m_count", f), m_count, cnt);
            chk($sformatf("rnd%0d_m_ovf", f), m_ovf, ov);
            model(q, md0, 2, mx, idx, cnt, ov);
            chk($sformatf("rnd%0d_m_max2", f), m_max2, mx);
            chk($sformatf("rnd%0d_m_index2", f), m_index2, idx);
            chk($sformatf("rnd%0d_m_count2", f), m_count2, cnt);
            chk($sformatf("rnd%0d_m_ovf2", f), m_ovf2, ov);
            model(q, md0, 8, mx, idx, cnt, ov);
            accept($urandom_range(0, 3), mx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
